// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state type and default sizing for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  localparam int DEF_REG_W        = 5;
  localparam int DEF_DRAIN_CYCLES = 3;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between decode sources and execute load destination
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  logic rd_nonzero;
  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired to zero, so a load targeting it can never feed a consumer
  assign rd_nonzero = (ex_rd != '0);
  assign rs1_match  = (ex_rd == id_rs1);
  assign rs2_match  = id_uses_rs2 & (ex_rd == id_rs2);

  assign load_use = id_valid & ex_valid & ex_is_load & rd_nonzero & (rs1_match | rs2_match);

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - stall/flush sequencer with halt/drain/resume; optional PIPE_PERF_COUNTERS_EN perf counters
module pipeline_control
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = DEF_REG_W,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_halt,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             resume,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             stall_de,
  output logic             stall_em,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  pipe_state_t        state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               load_use;
  logic               halt_req;
  logic               s_pc, s_fd, s_de, s_em, f_fd, f_de;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign halt_req = id_valid & id_halt;

  always_comb begin
    s_pc = 1'b0;
    s_fd = 1'b0;
    s_de = 1'b0;
    s_em = 1'b0;
    f_fd = 1'b0;
    f_de = 1'b0;
    case (state)
      RUN: begin
        if (mem_busy) begin
          {s_pc, s_fd, s_de, s_em} = 4'b1111;
        end else if (ex_branch_taken) begin
          {f_fd, f_de} = 2'b11;
        end else if (load_use || halt_req) begin
          {s_pc, s_fd, f_de} = 3'b111;
        end
      end
      DRAIN: begin
        if (mem_busy) begin
          {s_pc, s_fd, s_de, s_em} = 4'b1111;
        end else if (ex_branch_taken) begin
          {f_fd, f_de} = 2'b11;
        end else begin
          {s_pc, s_fd, f_de} = 3'b111;
        end
      end
      HALTED: begin
        {s_pc, s_fd, s_de, s_em} = 4'b1111;
        // Release fetch and drop the HALT sitting in F->D; older stages stay frozen this cycle
        if (resume) begin
          {s_pc, s_fd, f_fd} = 3'b001;
        end
      end
      default: ;
    endcase
  end

  // Flush beats stall on each register; nothing is driven while reset is held
  assign stall_pc = s_pc & ~reset;
  assign stall_fd = s_fd & ~f_fd & ~reset;
  assign stall_de = s_de & ~f_de & ~reset;
  assign stall_em = s_em & ~reset;
  assign flush_fd = f_fd & ~reset;
  assign flush_de = f_de & ~reset;
  assign halted   = (state == HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!mem_busy && !ex_branch_taken && !load_use && halt_req) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (mem_busy) begin
            drain_cnt <= drain_cnt;
          end else if (ex_branch_taken) begin
            state <= RUN;
          end else if (drain_cnt == '0) begin
            state <= HALTED;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        HALTED: begin
          if (resume) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_pc) stall_q <= stall_q + CNT_W'(1);
      if (flush_fd) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
